// File: rtl/spi_tx_master_if.sv
// Word-offer handshake between the register/DMA front end and the SPI transmit master.
interface spi_tx_master_if #(
  parameter int MAX_W = 32,
  parameter int LEN_W = $clog2(MAX_W) + 1
);
  logic             s_valid;
  logic             s_ready;
  logic [MAX_W-1:0] s_data;
  logic [LEN_W-1:0] s_len;
  logic             s_lsb_first;

  modport master (output s_valid, s_data, s_len, s_lsb_first, input s_ready);
  modport slave  (input s_valid, s_data, s_len, s_lsb_first, output s_ready);
endinterface

// File: rtl/spi_tx_master.sv
// SPI transmit master: serialises variable-length words onto SCLK/MOSI/CS_N with
// selectable CPOL/CPHA, bit order and SCLK division; chains frames through HOLD.
module spi_tx_master #(
  parameter int MAX_W   = 32,
  parameter int MIN_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_W) + 1,
  parameter int DIV_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  spi_tx_master_if.slave   s,
  input  logic             cfg_cpol_i,
  input  logic             cfg_cpha_i,
  input  logic [DIV_W-1:0] cfg_div_i,
  output logic             sclk_o,
  output logic             mosi_o,
  output logic             cs_n_o,
  output logic             busy_o,
  output logic             txe_flag_o,
  output logic             tx_done_o,
  output logic [LEN_W-1:0] bit_count_o
);

  localparam int TW = LEN_W + 1;
  localparam int IW = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    logic [LEN_W-1:0] r;
    r = l;
    if (l < LEN_W'(MIN_LEN)) r = LEN_W'(MIN_LEN);
    if (l > LEN_W'(MAX_W))   r = LEN_W'(MAX_W);
    return r;
  endfunction

  // k-th transmitted bit of a word of length len in the requested order.
  function automatic logic pick_bit(input logic [MAX_W-1:0] d, input logic [LEN_W-1:0] len,
                                    input logic lsb, input logic [LEN_W-1:0] k);
    logic [LEN_W-1:0] idx;
    idx = lsb ? k : (len - LEN_W'(1) - k);
    return d[idx[IW-1:0]];
  endfunction

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d;
  logic [TW-1:0]    tog_q, tog_d, tog_nx;
  logic [LEN_W-1:0] bitc_q, bitc_d, len_q, len_d, half_nx, acc_len;
  logic [MAX_W-1:0] data_q, data_d;
  logic lsb_q, lsb_d, cpol_q, cpol_d, cpha_q, cpha_d;
  logic sclk_q, sclk_d, mosi_q, mosi_d, csn_q, csn_d;
  logic done_q, done_d, txe_q, txe_d, rdyen_q;
  logic tick, ready, accept;

  assign tick      = (cnt_q == '0);
  assign ready     = rdyen_q && ((state_q == IDLE) || ((state_q == HOLD) && tick));
  assign s.s_ready = ready;
  assign accept    = s.s_valid && ready;
  assign acc_len   = clamp_len(s.s_len);
  assign tog_nx    = tog_q + 1'b1;
  assign half_nx   = tog_nx[TW-1:1];

  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? div_q : cnt_q - 1'b1;
    tog_d   = tog_q;
    bitc_d  = bitc_q;
    data_d  = data_q;
    len_d   = len_q;
    lsb_d   = lsb_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    div_d   = div_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    csn_d   = csn_q;
    done_d  = 1'b0;
    txe_d   = 1'b0;
    case (state_q)
      IDLE: begin
        sclk_d = cfg_cpol_i;
        csn_d  = 1'b1;
        mosi_d = 1'b0;
      end
      SETUP: if (tick) begin
        state_d = SHIFT;
        sclk_d  = ~sclk_q;
        tog_d   = tog_nx;
        if (cpha_q) mosi_d = pick_bit(data_q, len_q, lsb_q, '0);
      end
      SHIFT: if (tick) begin
        // The final toggle has already returned sclk to CPOL; this half-period just closes the frame.
        if (tog_q == {len_q, 1'b0}) begin
          state_d = HOLD;
        end else begin
          sclk_d = ~sclk_q;
          tog_d  = tog_nx;
          if (!tog_nx[0]) begin
            bitc_d = half_nx;
            done_d = (half_nx == len_q);
            txe_d  = (half_nx == LEN_W'(1));
            if (!cpha_q && (half_nx < len_q)) mosi_d = pick_bit(data_q, len_q, lsb_q, half_nx);
          end else if (cpha_q) begin
            mosi_d = pick_bit(data_q, len_q, lsb_q, tog_q[TW-1:1]);
          end
        end
      end
      HOLD: if (tick) begin
        state_d = IDLE;
        csn_d   = 1'b1;
        mosi_d  = 1'b0;
        sclk_d  = cfg_cpol_i;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      data_d  = s.s_data;
      len_d   = acc_len;
      lsb_d   = s.s_lsb_first;
      cpol_d  = cfg_cpol_i;
      cpha_d  = cfg_cpha_i;
      div_d   = cfg_div_i;
      state_d = SETUP;
      cnt_d   = cfg_div_i;
      csn_d   = 1'b0;
      bitc_d  = '0;
      tog_d   = '0;
      sclk_d  = cfg_cpol_i;
      mosi_d  = cfg_cpha_i ? 1'b0 : pick_bit(s.s_data, acc_len, s.s_lsb_first, '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tog_q   <= '0;
      bitc_q  <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      csn_q   <= 1'b1;
      done_q  <= 1'b0;
      txe_q   <= 1'b0;
      rdyen_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tog_q   <= tog_d;
      bitc_q  <= bitc_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      csn_q   <= csn_d;
      done_q  <= done_d;
      txe_q   <= txe_d;
      rdyen_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
    len_q  <= len_d;
    lsb_q  <= lsb_d;
    cpol_q <= cpol_d;
    cpha_q <= cpha_d;
    div_q  <= div_d;
  end

  assign sclk_o      = sclk_q;
  assign mosi_o      = mosi_q;
  assign cs_n_o      = csn_q;
  assign busy_o      = (state_q != IDLE);
  assign txe_flag_o  = txe_q;
  assign tx_done_o   = done_q;
  assign bit_count_o = bitc_q;

endmodule

// File: tb/tb_spi_tx_master.sv
// Randomised bench for spi_tx_master: a per-cycle timing model derived from half-period
// arithmetic, plus frame-level checks of toggle count, pulses and the word a slave would see.
module tb_spi_tx_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_cpol = 1'b0;
  logic       cfg_cpha = 1'b0;
  logic [7:0] cfg_div = 8'd0;
  logic       sclk, mosi, cs_n, busy, txe, done;
  logic [5:0] bitc;

  int ncmp = 0;
  int nfail = 0;

  logic [31:0] w_data [4];
  int          w_len  [4];
  bit          w_lsb  [4];
  bit          w_cpol [4];
  bit          w_cpha [4];
  logic [7:0]  w_div  [4];

  spi_tx_master_if bus ();

  spi_tx_master dut (
    .clk(clk), .rst(rst), .s(bus),
    .cfg_cpol_i(cfg_cpol), .cfg_cpha_i(cfg_cpha), .cfg_div_i(cfg_div),
    .sclk_o(sclk), .mosi_o(mosi), .cs_n_o(cs_n), .busy_o(busy),
    .txe_flag_o(txe), .tx_done_o(done), .bit_count_o(bitc)
  );

  always #5 clk = ~clk;

  function automatic int clampl(input int l);
    if (l < 8) return 8;
    if (l > 32) return 32;
    return l;
  endfunction

  function automatic logic ebit(input logic [63:0] d, input int L, input bit lsb, input int k);
    logic [63:0] t;
    t = lsb ? (d >> k) : (d >> (L - 1 - k));
    return t[0];
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Expected {s_ready,sclk,mosi,cs_n,busy,txe,done,bit_count} n cycles after the accept edge.
  function automatic logic [12:0] model(input int n, input int L, input int h, input bit cpol,
                                        input bit cpha, input logic [63:0] d, input bit lsb,
                                        input bit idle_cpol);
    int p, r;
    logic sc, mo;
    p = n / h;
    r = n % h;
    if (p >= 2 * L + 2) return {1'b1, idle_cpol, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'(L)};
    sc = (p >= 1 && p <= 2 * L) ? (cpol ^ (p % 2 == 1)) : cpol;
    if (!cpha) mo = ebit(d, L, lsb, imin(p / 2, L - 1));
    else       mo = (p == 0) ? 1'b0 : ebit(d, L, lsb, imin((p - 1) / 2, L - 1));
    return {(p == 2 * L + 1) && (r == h - 1), sc, mo, 1'b0, 1'b1, (n == 2 * h), (n == 2 * L * h),
            6'(imin(p / 2, L))};
  endfunction

  function automatic logic [12:0] observed();
    return {bus.s_ready, sclk, mosi, cs_n, busy, txe, done, bitc};
  endfunction

  task automatic drive_word(input int i);
    bus.s_data      = w_data[i];
    bus.s_len       = 6'(w_len[i]);
    bus.s_lsb_first = w_lsb[i];
    cfg_cpol        = w_cpol[i];
    cfg_cpha        = w_cpha[i];
    cfg_div         = w_div[i];
  endtask

  task automatic run_seq(input string nm, input int nw, input bit midchg);
    int L, h, tot, lastn, tg, nd, nt, k;
    logic [12:0] ev, av;
    logic [63:0] rx, erx, msk;
    logic prev;
    drive_word(0);
    bus.s_valid = 1'b1;
    k = 0;
    while (!bus.s_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    ncmp++;
    if (!bus.s_ready) begin
      nfail++;
      $display("FAIL %s ready_timeout got=%b exp=1", nm, bus.s_ready);
      bus.s_valid = 1'b0;
      return;
    end
    for (int i = 0; i < nw; i++) begin
      L = clampl(w_len[i]);
      h = int'(w_div[i]) + 1;
      tot = (2 * L + 2) * h;
      lastn = (i + 1 < nw) ? tot - 1 : tot;
      tg = 0; nd = 0; nt = 0; rx = '0;
      @(posedge clk); #1;
      if (i + 1 < nw) drive_word(i + 1);
      else bus.s_valid = 1'b0;
      prev = sclk;
      for (int n = 0; n <= lastn; n++) begin
        if (midchg && n == 5) begin
          cfg_cpol = ~w_cpol[i];
          cfg_cpha = ~w_cpha[i];
          cfg_div  = w_div[i] ^ 8'h5A;
        end
        ev = model(n, L, h, w_cpol[i], w_cpha[i], {32'd0, w_data[i]}, w_lsb[i], cfg_cpol);
        av = observed();
        ncmp++;
        if (av !== ev) begin
          nfail++;
          $display("FAIL %s word%0d cycle=%0d got=%b exp=%b", nm, i, n, av, ev);
        end
        if (n < tot) begin
          if (sclk !== prev) begin
            tg++;
            if (sclk == (w_cpha[i] ? w_cpol[i] : ~w_cpol[i])) rx = {rx[62:0], mosi};
          end
          if (done) nd++;
          if (txe) nt++;
        end
        prev = sclk;
        if (n < lastn) begin
          @(posedge clk); #1;
        end
      end
      msk = (64'd1 << L) - 64'd1;
      erx = '0;
      if (w_lsb[i]) begin
        for (int j = 0; j < L; j++) erx = (erx << 1) | ({32'd0, w_data[i]} >> j & 64'd1);
      end else begin
        erx = {32'd0, w_data[i]} & msk;
      end
      ncmp++;
      if (tg != 2 * L) begin
        nfail++;
        $display("FAIL %s word%0d toggles got=%0d exp=%0d", nm, i, tg, 2 * L);
      end
      ncmp++;
      if (nd != 1 || nt != 1) begin
        nfail++;
        $display("FAIL %s word%0d pulses done/txe got=%0d/%0d exp=1/1", nm, i, nd, nt);
      end
      ncmp++;
      if ((rx & msk) !== erx) begin
        nfail++;
        $display("FAIL %s word%0d slave_word got=%h exp=%h", nm, i, rx & msk, erx);
      end
    end
  endtask

  task automatic set_word(input int i, input logic [31:0] d, input int l, input bit lsb,
                          input bit cpol, input bit cpha, input logic [7:0] dv);
    w_data[i] = d; w_len[i] = l; w_lsb[i] = lsb;
    w_cpol[i] = cpol; w_cpha[i] = cpha; w_div[i] = dv;
  endtask

  task automatic test_reset();
    logic [12:0] av;
    rst = 1'b1;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_len = '0; bus.s_lsb_first = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    av = observed();
    ncmp++;
    if (av !== 13'b0_0_0_1_0_0_0_000000) begin
      nfail++;
      $display("FAIL reset_values got=%b exp=%b", av, 13'b0_0_0_1_0_0_0_000000);
    end
    rst = 1'b0;
    #1;
    ncmp++;
    if (bus.s_ready !== 1'b0) begin
      nfail++;
      $display("FAIL ready_before_edge got=%b exp=0", bus.s_ready);
    end
    @(posedge clk); #1;
    ncmp++;
    if (bus.s_ready !== 1'b1 || sclk !== 1'b0 || cs_n !== 1'b1) begin
      nfail++;
      $display("FAIL ready_after_reset got=%b%b%b exp=101", bus.s_ready, sclk, cs_n);
    end
  endtask

  task automatic test_basic();
    set_word(0, 32'h0000_00A5, 8, 1'b0, 1'b0, 1'b0, 8'd0);
    run_seq("basic_a5", 1, 1'b0);
  endtask

  task automatic test_len_clamp();
    set_word(0, $urandom, 3, 1'b0, 1'b0, 1'b0, 8'd0);
    run_seq("len3", 1, 1'b0);
    set_word(0, $urandom, 0, 1'b1, 1'b1, 1'b0, 8'd1);
    run_seq("len0", 1, 1'b0);
    set_word(0, $urandom, 40, 1'b0, 1'b0, 1'b1, 8'd0);
    run_seq("len40", 1, 1'b0);
    set_word(0, $urandom, 32, 1'b1, 1'b0, 1'b0, 8'd0);
    run_seq("len32", 1, 1'b0);
  endtask

  task automatic test_modes();
    for (int m = 0; m < 4; m++) begin
      set_word(0, 32'h1, 8, 1'b1, m[1], m[0], 8'd3);
      run_seq($sformatf("mode%0d", m), 1, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    bit cp, ch;
    cp = 1'($urandom); ch = 1'($urandom);
    for (int i = 0; i < 3; i++) set_word(i, $urandom, 8 + i * 2, 1'($urandom), cp, ch, 8'd1);
    run_seq("b2b", 3, 1'b0);
    for (int i = 0; i < 3; i++)
      set_word(i, $urandom, $urandom_range(0, 40), 1'($urandom), 1'($urandom), 1'($urandom),
               8'($urandom_range(0, 2)));
    run_seq("b2b_mixed", 3, 1'b0);
  endtask

  task automatic test_reset_midframe();
    logic [12:0] av;
    set_word(0, $urandom, 16, 1'b0, 1'b0, 1'b0, 8'd1);
    drive_word(0);
    bus.s_valid = 1'b1;
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    ncmp++;
    if (bitc !== 6'd5) begin
      nfail++;
      $display("FAIL abort_point bit_count got=%0d exp=5", bitc);
    end
    rst = 1'b1;
    #1;
    av = observed();
    ncmp++;
    if (av !== 13'b0_0_0_1_0_0_0_000000) begin
      nfail++;
      $display("FAIL abort_reset got=%b exp=%b", av, 13'b0_0_0_1_0_0_0_000000);
    end
    @(posedge clk); #1;
    ncmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL abort_no_done got=%b%b exp=00", done, busy);
    end
    rst = 1'b0;
    set_word(0, $urandom, 16, 1'b1, 1'b0, 1'b0, 8'd1);
    run_seq("after_abort", 1, 1'b0);
  endtask

  task automatic test_cfg_midframe();
    set_word(0, $urandom, 12, 1'b0, 1'b0, 1'b1, 8'd2);
    run_seq("cfg_change", 1, 1'b1);
    set_word(0, $urandom, 9, 1'b1, 1'b1, 1'b0, 8'd0);
    run_seq("cfg_next", 1, 1'b0);
  endtask

  task automatic test_div_max();
    set_word(0, $urandom, 8, 1'b0, 1'b1, 1'b1, 8'd255);
    run_seq("div_max", 1, 1'b0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      set_word(0, $urandom, $urandom_range(0, 40), 1'($urandom), 1'($urandom), 1'($urandom),
               8'($urandom_range(0, 3)));
      run_seq($sformatf("rand%0d", t), 1, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len_clamp();
    test_modes();
    test_back_to_back();
    test_reset_midframe();
    test_cfg_midframe();
    test_div_max();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
